// File: rtl/pnc_dispatch_router_if.sv
// Request/issue bundle between the host/SWU request side and the pnc_dispatch_router.
// PNC_ISSUE_STATS_EN adds the per-target issue_cnt vector.
interface pnc_dispatch_router_if #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int SWU_DATA_W = 8,
  parameter int TGT_W      = 2,
  parameter int NUM_TGT    = 3,
  parameter int LOC_ADDR_W = 7,
  parameter int FIFO_DEPTH = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                          kill;
  logic                          host_valid;
  logic                          host_ready;
  logic [ADDR_W-1:0]             host_addr;
  logic [DATA_W-1:0]             host_data;
  logic                          swu_valid;
  logic                          swu_ready;
  logic [ADDR_W-1:0]             swu_addr;
  logic [SWU_DATA_W-1:0]         swu_data;
  logic [NUM_TGT-1:0]            tgt_en;
  logic [NUM_TGT-1:0]            tgt_ready;
  logic [NUM_TGT-1:0]            tgt_we;
  logic [NUM_TGT-1:0]            tgt_rc;
  logic [NUM_TGT*LOC_ADDR_W-1:0] tgt_addr;
  logic [NUM_TGT*DATA_W-1:0]     tgt_data;
  logic                          err_pulse;
  logic [LVL_W-1:0]              fifo_level;
`ifdef PNC_ISSUE_STATS_EN
  logic [NUM_TGT*16-1:0]         issue_cnt;
`endif

  modport master (
`ifdef PNC_ISSUE_STATS_EN
    input  issue_cnt,
`endif
    output kill, host_valid, host_addr, host_data, swu_valid, swu_addr, swu_data, tgt_ready,
    input  host_ready, swu_ready, tgt_en, tgt_we, tgt_rc, tgt_addr, tgt_data, err_pulse, fifo_level
  );

  modport slave (
`ifdef PNC_ISSUE_STATS_EN
    output issue_cnt,
`endif
    input  kill, host_valid, host_addr, host_data, swu_valid, swu_addr, swu_data, tgt_ready,
    output host_ready, swu_ready, tgt_en, tgt_we, tgt_rc, tgt_addr, tgt_data, err_pulse, fifo_level
  );
endinterface

// File: rtl/pnc_dispatch_router.sv
// Buffers host/SWU requests in a FIFO, decodes the opcode and issues each to one of NUM_TGT units.
// Define PNC_ISSUE_STATS_EN to add saturating per-target completed-issue counters (issue_cnt).
module pnc_dispatch_router #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int SWU_DATA_W = 8,
  parameter int TGT_W      = 2,
  parameter int NUM_TGT    = 3,
  parameter int LOC_ADDR_W = 7,
  parameter int FIFO_DEPTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  pnc_dispatch_router_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int OP_W  = TGT_W + 2;
  localparam int ENT_W = OP_W + LOC_ADDR_W + DATA_W;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [ENT_W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level;
  logic                  flush;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  done;
  logic                  sel_ready;
  logic [ADDR_W-1:0]     in_addr;
  logic [DATA_W-1:0]     in_data;
  logic [ENT_W-1:0]      head;
  logic [OP_W-1:0]       head_op;
  logic [LOC_ADDR_W-1:0] head_loc;
  logic [DATA_W-1:0]     head_data;
  logic                  unused_addr;

  logic [0:0]            state;
  logic [TGT_W-1:0]      cur_idx;
  logic                  cur_wr;
  logic                  cur_rc;
  logic                  cur_legal;
  logic [LOC_ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0]     cur_data;
  logic [NUM_TGT-1:0]    en_v;

  assign flush = !rst || bus.kill;
  assign full  = (level == LVL_W'(FIFO_DEPTH));
  assign empty = (level == '0);

  // Readiness comes from the registered level only, so a same-cycle pop never frees a full FIFO.
  assign bus.swu_ready  = !full && !bus.kill && rst;
  assign bus.host_ready = bus.swu_ready && !bus.swu_valid;
  assign push           = bus.swu_ready && (bus.swu_valid || bus.host_valid);

  assign in_addr     = bus.swu_valid ? bus.swu_addr : bus.host_addr;
  assign in_data     = bus.swu_valid ? DATA_W'(bus.swu_data) : bus.host_data;
  assign unused_addr = ^in_addr;

  assign head = mem[rd_ptr];
  assign {head_op, head_loc, head_data} = head;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_addr[ADDR_W-1 -: OP_W], in_addr[LOC_ADDR_W-1:0], in_data};
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(push) - LVL_W'(pop);
    end
  end

  always_comb begin
    sel_ready = 1'b0;
    en_v      = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (cur_idx == TGT_W'(i)) begin
        sel_ready = bus.tgt_ready[i];
        en_v[i]   = (state == ST_ISSUE) && cur_legal;
      end
    end
  end

  // An illegal entry spends one ISSUE cycle signalling err_pulse and then retires like a completed issue.
  assign done = (state == ST_ISSUE) && (!cur_legal || sel_ready);
  assign pop  = !empty && ((state == ST_IDLE) || done);

  always_ff @(posedge clk) begin
    if (flush) begin
      state     <= ST_IDLE;
      cur_idx   <= '0;
      cur_wr    <= 1'b0;
      cur_rc    <= 1'b0;
      cur_legal <= 1'b0;
      cur_addr  <= '0;
      cur_data  <= '0;
    end else if (pop) begin
      state     <= ST_ISSUE;
      cur_idx   <= head_op[OP_W-1:2];
      cur_wr    <= head_op[1];
      cur_rc    <= head_op[0];
      cur_legal <= (32'(head_op[OP_W-1:2]) < NUM_TGT);
      cur_addr  <= head_loc;
      cur_data  <= head_data;
    end else if (done) begin
      state <= ST_IDLE;
    end
  end

  always_comb begin
    bus.tgt_addr = '0;
    bus.tgt_data = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (en_v[i]) begin
        bus.tgt_addr[i*LOC_ADDR_W +: LOC_ADDR_W] = cur_addr;
        bus.tgt_data[i*DATA_W +: DATA_W]         = cur_data;
      end
    end
  end

  assign bus.tgt_en     = en_v;
  assign bus.tgt_we     = cur_wr ? en_v : '0;
  assign bus.tgt_rc     = cur_rc ? en_v : '0;
  assign bus.err_pulse  = (state == ST_ISSUE) && !cur_legal;
  assign bus.fifo_level = level;

`ifdef PNC_ISSUE_STATS_EN
  logic [15:0] issue_q [NUM_TGT];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_TGT; i++) begin
      if (flush) begin
        issue_q[i] <= '0;
      end else if (en_v[i] && bus.tgt_ready[i] && (issue_q[i] != 16'hFFFF)) begin
        issue_q[i] <= issue_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    bus.issue_cnt = '0;
    for (int i = 0; i < NUM_TGT; i++) bus.issue_cnt[i*16 +: 16] = issue_q[i];
  end
`endif
endmodule
